branch_resolve_unit: RTL
========================

# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the backend execute stage. Accepts in-order branch micro-ops from issue, evaluates all sixteen AArch64 condition codes plus CBZ/CBNZ/BR, computes the actual target, and compares it against the frontend prediction. Buffers up to FIFO_DEPTH branches and returns results to the ROB over a valid/ready handshake. Raises a one-cycle redirect on mispredict, squashes younger buffered branches, and writes the BL link register.

## Interface
- ADDR_W, 64, PC and target width
- OFFSET_W, 26, signed word-offset width of immediate branches
- FIFO_DEPTH, 4, input buffer entries (power of two, ≥2)
- TAG_W, 6, ROB tag width
- PREG_W, 7, physical register index width
- clk_in  in  1  clock; one clock domain
- rst_in  in  1  reset; synchronous, active-high
- flush_in  in  1  ROB flush; clears all state at next edge
- in_valid / in_ready  in / out  1 / 1  input handshake
- in_op  in  3  0=B, 1=BL, 2=BCOND, 3=CBZ, 4=CBNZ, 5=BR; 6–7 illegal
- in_cond  in  4  condition field (BCOND only)
- in_nzcv  in  4  flags: [3]=N, [2]=Z, [1]=C, [0]=V
- in_pc  in  ADDR_W  branch PC
- in_offset  in  OFFSET_W  signed word offset
- in_rs_val  in  64  register operand (CBZ/CBNZ test value, BR target)
- in_pred_taken / in_pred_target  in  1 / ADDR_W  frontend prediction
- in_rob_tag / in_dest_phys  in  TAG_W / PREG_W  ROB tag; link destination
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_rob_tag, out_taken, out_target, out_mispredict  out  TAG_W, 1, ADDR_W, 1  resolved result
- wb_en, wb_index, wb_data  out  1, PREG_W, 64  link write
- redirect_valid, redirect_pc  out  1, ADDR_W  frontend redirect

## Operation
- Stage 0 is a circular FIFO with read and write pointers that wrap modulo FIFO_DEPTH, plus a count. Stage 1 is the result register.
- in_ready = !full. It does not look ahead at a same-cycle pop.
- The FIFO head moves to stage 1 when stage 1 is empty, or when it holds a result that is handshaking this cycle.
- Resolution of the head entry:
  - Not-taken path = pc+4.
  - Immediate target = pc + (sext(offset)<<2), computed modulo 2^ADDR_W.
  - B and BL: always taken, immediate target.
  - BCOND taken conditions:
    - EQ/NE: Z / !Z
    - CS/CC: C / !C
    - MI/PL: N / !N
    - VS/VC: V / !V
    - HI: C&!Z; LS: !C|Z
    - GE: N==V; LT: N!=V
    - GT: !Z&(N==V); LE: Z|(N!=V)
    - AL and NV (1110, 1111): always taken
  - CBZ: taken iff rs_val==0. CBNZ: taken iff rs_val!=0. Both use the immediate target.
  - BR: taken, target = rs_val (truncated to ADDR_W).
  - Illegal op: not taken.
- out_target is the taken target when taken, pc+4 when not taken.
- out_mispredict = (taken != pred_taken) | (taken & (target != pred_target)).
- When the head is loaded into stage 1 with a mispredict:
  - The FIFO is cleared on that same edge.
  - An input accepted in that same cycle is discarded.
  - redirect_valid is high for exactly one cycle (the first cycle of out_valid for that entry), with redirect_pc = out_target.
- BL: wb_en is pulsed for one cycle, in the first out_valid cycle, with wb_index = dest_phys and wb_data = zero-extended pc+4. wb_en is independent of out_ready.
- Stage 1 holds a result stable while out_valid & !out_ready.
- flush_in, or rst_in, at an edge clears the FIFO, stage 1 and all pulses. flush_in is ignored-equivalent during rst_in. A flush has priority over a same-cycle push, pop or load.

## Timing
- Reset values: in_ready=1 on the cycle after reset. out_valid, wb_en and redirect_valid are 0. All data outputs are 0.
- Latency: input accepted at edge t → out_valid at cycle t+1 and redirect/wb pulses at cycle t+1, when the FIFO and stage 1 were empty.
- Throughput is one branch per cycle with out_ready held high.
- FIFO full with a pop in the same cycle: in_ready stays 0 that cycle and rises the next cycle.

## Configuration
- BRU_PERF_CNT_EN defined: adds two outputs, perf_resolved[31:0] and perf_mispredict[31:0].
  - Both reset to 0 on rst_in; flush_in does not clear them.
  - Each increments by 1 on each out_valid&out_ready handshake (the mispredict counter only when out_mispredict=1).
  - Both saturate at 0xFFFFFFFF.
- BRU_PERF_CNT_EN undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- BCOND GT, nzcv=0000, pc=0x1000, offset=4, pred_taken=1, pred_target=0x1010 → one cycle later out_taken=1, target=0x1010, mispredict=0, no redirect.
- BCOND EQ, nzcv=0000, pc=0x2000, pred_taken=1 → out_taken=0, target=0x2004, mispredict=1. redirect_valid pulses one cycle with 0x2004. Three queued younger branches are dropped and never appear on out.
- BL, pc=0x3000, offset=-2, dest_phys=30 → target=0x2FF8. wb_en pulse with index 30, data 0x3004.
- Push 5 branches with out_ready=0 (FIFO_DEPTH=4) → in_ready=0 after 4 are buffered plus 1 in stage 1. Raise out_ready → results drain in order, and in_ready returns 1 one cycle after the first pop.
- CBZ rs_val=0 and CBNZ rs_val=0, same offset → first taken, second not taken. BR rs_val=0xDEAD_BEE0 → target 0xDEAD_BEE0.
- Assert flush_in with 3 buffered entries and out_valid=1 → next cycle out_valid=0 and FIFO empty. With BRU_PERF_CNT_EN defined, the counters keep their values.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Issue-side, ROB-side, writeback and redirect signals of branch_resolve_unit.
// The slave modport is the unit's view. The master modport is the view of the issue stage, ROB and frontend.
interface branch_resolve_unit_if #(
    parameter int ADDR_W   = 64,
    parameter int OFFSET_W = 26,
    parameter int TAG_W    = 6,
    parameter int PREG_W   = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_op;
    logic [3:0]          in_cond;
    logic [3:0]          in_nzcv;
    logic [ADDR_W-1:0]   in_pc;
    logic [OFFSET_W-1:0] in_offset;
    logic [63:0]         in_rs_val;
    logic                in_pred_taken;
    logic [ADDR_W-1:0]   in_pred_target;
    logic [TAG_W-1:0]    in_rob_tag;
    logic [PREG_W-1:0]   in_dest_phys;

    logic                out_valid;
    logic                out_ready;
    logic [TAG_W-1:0]    out_rob_tag;
    logic                out_taken;
    logic [ADDR_W-1:0]   out_target;
    logic                out_mispredict;

    logic                wb_en;
    logic [PREG_W-1:0]   wb_index;
    logic [63:0]         wb_data;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;

    modport master (
        output in_valid, in_op, in_cond, in_nzcv, in_pc, in_offset, in_rs_val,
               in_pred_taken, in_pred_target, in_rob_tag, in_dest_phys, out_ready,
        input  in_ready, out_valid, out_rob_tag, out_taken, out_target, out_mispredict,
               wb_en, wb_index, wb_data, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_op, in_cond, in_nzcv, in_pc, in_offset, in_rs_val,
               in_pred_taken, in_pred_target, in_rob_tag, in_dest_phys, out_ready,
        output in_ready, out_valid, out_rob_tag, out_taken, out_target, out_mispredict,
               wb_en, wb_index, wb_data, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: circular FIFO (stage 0) feeding a result register (stage 1) toward the ROB.
// Optional macro BRU_PERF_CNT_EN adds saturating resolved and mispredict counters.
module branch_resolve_unit #(
    parameter int ADDR_W     = 64,
    parameter int OFFSET_W   = 26,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 6,
    parameter int PREG_W     = 7
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 flush_in,
    branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]          perf_resolved,
    output logic [31:0]          perf_mispredict
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [2:0] OP_B = 3'd0, OP_BL = 3'd1, OP_BCOND = 3'd2,
                           OP_CBZ = 3'd3, OP_CBNZ = 3'd4, OP_BR = 3'd5;

    typedef struct packed {
        logic [2:0]          op;
        logic [3:0]          cond;
        logic [3:0]          nzcv;
        logic [ADDR_W-1:0]   pc;
        logic [OFFSET_W-1:0] offset;
        logic [63:0]         rs_val;
        logic                pred_taken;
        logic [ADDR_W-1:0]   pred_target;
        logic [TAG_W-1:0]    rob_tag;
        logic [PREG_W-1:0]   dest_phys;
    } entry_t;

    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z & (n == v);
            default: r = 1'b1;
        endcase
        // Odd encodings invert the even one, except NV which is always taken like AL.
        if (cond[0] && cond[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    function automatic logic [ADDR_W-1:0] imm_target(input logic [ADDR_W-1:0] pc,
                                                    input logic signed [OFFSET_W-1:0] offset);
        logic signed [ADDR_W-1:0] byte_off;
        byte_off = {{(ADDR_W-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
        return pc + byte_off;
    endfunction

    entry_t             mem_p0 [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_p0, rd_ptr_p0;
    logic [PTR_W:0]     count_p0;
    entry_t             head_p0;
    logic               full_p0, push_p0, load_p0, squash_p0;
    logic               taken_p0, mispredict_p0;
    logic [ADDR_W-1:0]  seq_pc_p0, taken_tgt_p0, target_p0;

    logic               vld_p1, redirect_p1, wb_en_p1;
    logic               taken_p1, mispredict_p1;
    logic [ADDR_W-1:0]  target_p1, link_p1;
    logic [TAG_W-1:0]   rob_tag_p1;
    logic [PREG_W-1:0]  dest_p1;

    assign head_p0   = mem_p0[rd_ptr_p0];
    assign full_p0   = (count_p0 == (PTR_W+1)'(FIFO_DEPTH));
    assign push_p0   = bus.in_valid & !full_p0;
    assign load_p0   = (count_p0 != '0) & (!vld_p1 | bus.out_ready);
    assign squash_p0 = load_p0 & mispredict_p0;

    always_comb begin
        seq_pc_p0    = head_p0.pc + ADDR_W'(4);
        taken_tgt_p0 = imm_target(head_p0.pc, head_p0.offset);
        taken_p0     = 1'b0;
        case (head_p0.op)
            OP_B, OP_BL: taken_p0 = 1'b1;
            OP_BCOND:    taken_p0 = cond_taken(head_p0.cond, head_p0.nzcv);
            OP_CBZ:      taken_p0 = (head_p0.rs_val == 64'd0);
            OP_CBNZ:     taken_p0 = (head_p0.rs_val != 64'd0);
            OP_BR: begin
                taken_p0     = 1'b1;
                taken_tgt_p0 = head_p0.rs_val[ADDR_W-1:0];
            end
            default:     taken_p0 = 1'b0;
        endcase
        target_p0     = taken_p0 ? taken_tgt_p0 : seq_pc_p0;
        mispredict_p0 = (taken_p0 != head_p0.pred_taken) |
                        (taken_p0 & (taken_tgt_p0 != head_p0.pred_target));
    end

    // Stage 0 -> stage 1 control: a mispredicting head empties the FIFO and drops any same-cycle push.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            wr_ptr_p0   <= '0;
            rd_ptr_p0   <= '0;
            count_p0    <= '0;
            vld_p1      <= 1'b0;
            redirect_p1 <= 1'b0;
            wb_en_p1    <= 1'b0;
        end else begin
            if (squash_p0) begin
                wr_ptr_p0 <= '0;
                rd_ptr_p0 <= '0;
                count_p0  <= '0;
            end else begin
                wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(push_p0);
                rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(load_p0);
                count_p0  <= count_p0 + (PTR_W+1)'(push_p0) - (PTR_W+1)'(load_p0);
            end
            if (load_p0) vld_p1 <= 1'b1;
            else if (bus.out_ready) vld_p1 <= 1'b0;
            redirect_p1 <= squash_p0;
            wb_en_p1    <= load_p0 & (head_p0.op == OP_BL);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_p0) begin
            mem_p0[wr_ptr_p0] <= '{op: bus.in_op, cond: bus.in_cond, nzcv: bus.in_nzcv,
                                   pc: bus.in_pc, offset: bus.in_offset, rs_val: bus.in_rs_val,
                                   pred_taken: bus.in_pred_taken, pred_target: bus.in_pred_target,
                                   rob_tag: bus.in_rob_tag, dest_phys: bus.in_dest_phys};
        end
        if (load_p0) begin
            taken_p1      <= taken_p0;
            target_p1     <= target_p0;
            mispredict_p1 <= mispredict_p0;
            rob_tag_p1    <= head_p0.rob_tag;
            dest_p1       <= head_p0.dest_phys;
            link_p1       <= seq_pc_p0;
        end
    end

    // Stage 1 outputs: data registers are not reset, so they are masked by their qualifiers.
    assign bus.in_ready       = !full_p0;
    assign bus.out_valid      = vld_p1;
    assign bus.out_rob_tag    = vld_p1 ? rob_tag_p1 : '0;
    assign bus.out_taken      = vld_p1 & taken_p1;
    assign bus.out_target     = vld_p1 ? target_p1 : '0;
    assign bus.out_mispredict = vld_p1 & mispredict_p1;
    assign bus.redirect_valid = redirect_p1;
    assign bus.redirect_pc    = redirect_p1 ? target_p1 : '0;
    assign bus.wb_en          = wb_en_p1;
    assign bus.wb_index       = wb_en_p1 ? dest_p1 : '0;
    assign bus.wb_data        = wb_en_p1 ? 64'(link_p1) : 64'd0;

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else if (vld_p1 && bus.out_ready) begin
            if (perf_resolved != 32'hFFFF_FFFF) perf_resolved <= perf_resolved + 32'd1;
            if (mispredict_p1 && perf_mispredict != 32'hFFFF_FFFF)
                perf_mispredict <= perf_mispredict + 32'd1;
        end
    end
`endif
endmodule
